// File: rtl/uart_cmd_rx_if.sv
// uart_cmd_rx_if: byte-in / command-out bundle for the UART command parser.
// Slave modport is the parser side, master is the uart/sequencer side.
interface uart_cmd_rx_if #(
  parameter int DP_WIDTH = 16,
  parameter int REG_W    = 1
);
  logic [7:0]          i_rx_data;
  logic                i_rx_valid;
  logic                o_cmd_valid;
  logic                i_cmd_rdy;
  logic [REG_W-1:0]    o_cmd_reg;
  logic [DP_WIDTH-1:0] o_cmd_data;
  logic                o_err;
  logic                o_overrun;

  modport slave (
    input  i_rx_data, i_rx_valid, i_cmd_rdy,
    output o_cmd_valid, o_cmd_reg, o_cmd_data, o_err, o_overrun
  );

  modport master (
    output i_rx_data, i_rx_valid, i_cmd_rdy,
    input  o_cmd_valid, o_cmd_reg, o_cmd_data, o_err, o_overrun
  );
endinterface

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: parses "R<d>:<hex>" lines from the UART byte stream.
// UART_CMD_LOWER_EN: also accept 'r' and lowercase hex digits.
module uart_cmd_rx #(
  parameter int DP_WIDTH = 16,
  parameter int NUM_NIB  = 4,
  parameter int REG_W    = 1
) (
  input logic clk,
  input logic rst,
  uart_cmd_rx_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REG   = 3'd1;
  localparam logic [2:0] S_COLON = 3'd2;
  localparam logic [2:0] S_NIB   = 3'd3;
  localparam logic [2:0] S_EOL   = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam int CW   = $clog2(NUM_NIB + 1);
  localparam int NREG = (REG_W >= 4) ? 10 : (1 << REG_W);
  localparam logic [CW-1:0] LAST = CW'(NUM_NIB - 1);

  logic [2:0]          state;
  logic [CW-1:0]       cnt;
  logic [DP_WIDTH-1:0] shreg;
  logic [REG_W-1:0]    reg_idx;

  logic [7:0] b;
  logic       is_term;
  logic       is_r;
  logic       is_dec;
  logic       dig_ok;
  logic       hex_ok;
  logic [3:0] hex_val;
  logic       pending;
  logic       take;

  // Classify the incoming byte.
  always_comb begin
    b       = bus.i_rx_data;
    is_term = (b == 8'h0D) || (b == 8'h0A);
    is_dec  = (b >= "0") && (b <= "9");
    dig_ok  = is_dec && (32'(b[3:0]) < NREG);
    hex_ok  = 1'b0;
    hex_val = 4'd0;
`ifdef UART_CMD_LOWER_EN
    is_r = (b == "R") || (b == "r");
`else
    is_r = (b == "R");
`endif
    if (is_dec) begin
      hex_ok  = 1'b1;
      hex_val = b[3:0];
    end else if ((b >= "A") && (b <= "F")) begin
      hex_ok  = 1'b1;
      hex_val = b[3:0] + 4'd9;
    end
`ifdef UART_CMD_LOWER_EN
    else if ((b >= "a") && (b <= "f")) begin
      hex_ok  = 1'b1;
      hex_val = b[3:0] + 4'd9;
    end
`endif
  end

  assign pending = bus.o_cmd_valid & ~bus.i_cmd_rdy;
  assign take    = bus.i_rx_valid & ~pending;

  // Line parser plus command/err/overrun output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      shreg           <= '0;
      reg_idx         <= '0;
      bus.o_cmd_valid <= 1'b0;
      bus.o_cmd_reg   <= '0;
      bus.o_cmd_data  <= '0;
      bus.o_err       <= 1'b0;
      bus.o_overrun   <= 1'b0;
    end else begin
      bus.o_err <= 1'b0;
      if (bus.o_cmd_valid && bus.i_cmd_rdy)
        bus.o_cmd_valid <= 1'b0;
      if (bus.i_rx_valid && pending)
        bus.o_overrun <= 1'b1;
      if (take) begin
        unique case (state)
          S_IDLE: begin
            if (is_r)
              state <= S_REG;
            else if (!is_term && (b != " "))
              state <= S_ERR;
          end
          S_REG: begin
            if (dig_ok) begin
              reg_idx <= REG_W'(b[3:0]);
              state   <= S_COLON;
            end else if (is_term) begin
              state     <= S_IDLE;
              bus.o_err <= 1'b1;
            end else begin
              state <= S_ERR;
            end
          end
          S_COLON: begin
            if (b == ":") begin
              shreg <= '0;
              cnt   <= '0;
              state <= S_NIB;
            end else if (is_term) begin
              state     <= S_IDLE;
              bus.o_err <= 1'b1;
            end else begin
              state <= S_ERR;
            end
          end
          S_NIB: begin
            if (hex_ok) begin
              shreg <= {shreg[DP_WIDTH-5:0], hex_val};
              cnt   <= cnt + CW'(1);
              if (cnt == LAST)
                state <= S_EOL;
            end else if (is_term) begin
              state     <= S_IDLE;
              bus.o_err <= 1'b1;
            end else begin
              state <= S_ERR;
            end
          end
          S_EOL: begin
            if (is_term) begin
              state           <= S_IDLE;
              bus.o_cmd_reg   <= reg_idx;
              bus.o_cmd_data  <= shreg;
              bus.o_cmd_valid <= 1'b1;
            end else begin
              state <= S_ERR;
            end
          end
          S_ERR: begin
            if (is_term) begin
              state     <= S_IDLE;
              bus.o_err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
